uart_rx_frame: RTL and testbench

//  UART receive framer; sits directly downstream of the RX baud generator.
//  - Consumes a one-cycle oversample tick and the raw rx line.
//  - Recovers start/data/parity/stop framing and presents each received word on a valid/ready interface with error flags.
//  - Feeds the RX FIFO / host register stage.

---
 rtl/uart_rx_frame.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receive framer: oversampled start/data/parity/stop recovery with a
// registered valid/ready output stage carrying parity, framing and overrun flags.
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 system_clk,
  input  logic                 reset_n,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_en_q;
  logic                 par_odd_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 done;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;

  // Two-flop synchroniser plus history flop; idle-high so reset never looks like a start edge.
  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Frame FSM; the stop bit is sampled mid-bit and IDLE is re-entered at once to resync early.
  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          if (rx_prev && !rx_s) begin
            state     <= START;
            busy      <= 1'b1;
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
          end
        end
        START: begin
          if (sample_tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (sample_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shift_q  <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                state  <= par_en_q ? PARITY : STOP;
                perr_q <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (sample_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              perr_q   <= (^shift_q) ^ rx_s ^ par_odd_q;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (sample_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              ferr_q   <= ~rx_s;
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  // Output register: a held word is never overwritten; a simultaneous consume frees the slot.
  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data    <= shift_q;
          parity_err <= perr_q;
          frame_err  <= ferr_q;
          rx_valid   <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: frames are serialised bit by bit, expected words
// are queued from a behavioural model and popped by a monitor on each handshake.
module tb_uart_rx_frame;
  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 4;
  localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic                 system_clk = 1'b0;
  logic                 reset_n    = 1'b0;
  logic                 sample_tick = 1'b0;
  logic                 rx_in      = 1'b1;
  logic                 parity_en  = 1'b0;
  logic                 parity_odd = 1'b0;
  logic                 rx_ready   = 1'b0;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  exp_t       sb[$];
  int         check_cnt = 0;
  int         error_cnt = 0;
  int         overrun_cnt = 0;
  int         exp_overruns = 0;
  int         overrun_run = 0;
  bit         rand_ready = 1'b0;
  bit         hold_prev = 1'b0;
  logic [7:0] held_data;
  logic       held_perr;
  logic       held_ferr;

  uart_rx_frame #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
    .system_clk (system_clk),
    .reset_n    (reset_n),
    .sample_tick(sample_tick),
    .rx_in      (rx_in),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 system_clk = ~system_clk;

  initial begin
    int c = 0;
    forever begin
      @(posedge system_clk);
      #1;
      sample_tick = (c == TICK_DIV - 1);
      c = (c + 1) % TICK_DIV;
    end
  end

  initial begin
    forever begin
      @(posedge system_clk);
      #1;
      if (rand_ready) rx_ready = ($urandom % 2) == 1;
    end
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      error_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: parity error when the count of ones (data + parity bit) disagrees with the mode.
  function automatic exp_t model(input logic [7:0] d, input bit pen, input bit podd,
                                 input bit pbit, input bit stop);
    exp_t e;
    int   ones;
    ones   = $countones(d) + int'(pbit);
    e.data = d;
    e.perr = pen ? ((ones % 2) != (podd ? 1 : 0)) : 1'b0;
    e.ferr = !stop;
    return e;
  endfunction

  task automatic driveBit(input bit b);
    rx_in = b;
    repeat (BIT_CLKS) @(posedge system_clk);
    #1;
  endtask

  task automatic sendRaw(input logic [7:0] d, input bit pen, input bit podd, input bit pbit);
    parity_en  = pen;
    parity_odd = podd;
    driveBit(1'b0);
    parity_en  = ($urandom % 2) == 1;
    parity_odd = ($urandom % 2) == 1;
    for (int i = 0; i < DATA_BITS; i++) driveBit(d[i]);
    if (pen) driveBit(pbit);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit pen, input bit podd,
                               input bit pbit, input bit stop, input bit push);
    if (push) sb.push_back(model(d, pen, podd, pbit, stop));
    sendRaw(d, pen, podd, pbit);
    driveBit(stop);
    rx_in = 1'b1;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 4000 && sb.size() != 0; i++) @(posedge system_clk);
    #1;
    checkOutput("drain", sb.size(), 0);
  endtask

  always @(negedge system_clk) begin
    if (overrun) begin
      if (overrun_run == 0) overrun_cnt++;
      overrun_run++;
    end else if (overrun_run > 0) begin
      checkOutput("overrun_len", overrun_run, 1);
      overrun_run = 0;
    end
    if (hold_prev && rx_valid && !rx_ready) begin
      checkOutput("hold_data", rx_data, held_data);
      checkOutput("hold_perr", parity_err, held_perr);
      checkOutput("hold_ferr", frame_err, held_ferr);
    end
    hold_prev = rx_valid && !rx_ready;
    held_data = rx_data;
    held_perr = parity_err;
    held_ferr = frame_err;
    if (rx_valid && rx_ready) begin
      checkOutput("word_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rx_data", rx_data, e.data);
        checkOutput("parity_err", parity_err, e.perr);
        checkOutput("frame_err", frame_err, e.ferr);
      end
    end
  end

  initial begin
    repeat (3) @(posedge system_clk);
    #1;
    checkOutput("rst_valid", rx_valid, 0);
    checkOutput("rst_data", rx_data, 0);
    checkOutput("rst_perr", parity_err, 0);
    checkOutput("rst_ferr", frame_err, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (10) @(posedge system_clk);
    #1;
    rx_ready = 1'b1;

    applyStimulus(8'h55, 0, 0, 0, 1, 1);
    waitDrain();
    checkOutput("t1_busy_after", busy, 0);

    // Short low pulse: rejected at the mid-start sample.
    rx_in = 1'b0;
    repeat (3 * TICK_DIV) @(posedge system_clk);
    #1;
    checkOutput("t2_busy_during", busy, 1);
    rx_in = 1'b1;
    repeat (BIT_CLKS) @(posedge system_clk);
    #1;
    checkOutput("t2_busy_after", busy, 0);
    checkOutput("t2_valid", rx_valid, 0);

    applyStimulus(8'hA3, 1, 0, 1, 1, 1);
    applyStimulus(8'hA3, 1, 0, 0, 1, 1);
    applyStimulus(8'hA3, 1, 1, 1, 1, 1);
    waitDrain();

    // Break: one framing error, no restart while the line stays low.
    sb.push_back(model(8'h3C, 0, 0, 0, 0));
    sendRaw(8'h3C, 0, 0, 0);
    repeat (20) driveBit(1'b0);
    waitDrain();
    checkOutput("t4_busy_break", busy, 0);
    rx_in = 1'b1;
    repeat (20) @(posedge system_clk);
    #1;
    applyStimulus(8'h81, 0, 0, 0, 1, 1);
    waitDrain();

    // Overrun, then a consume coinciding with the next completion.
    rx_ready = 1'b0;
    applyStimulus(8'h11, 0, 0, 0, 1, 1);
    applyStimulus(8'h22, 0, 0, 0, 1, 0);
    exp_overruns++;
    repeat (5) @(posedge system_clk);
    #1;
    checkOutput("t5_held_data", rx_data, 8'h11);
    fork
      applyStimulus(8'h22, 0, 0, 0, 1, 1);
      begin
        for (int i = 0; i < 4000 && !busy; i++) begin @(posedge system_clk); #1; end
        for (int i = 0; i < 4000 && busy; i++) begin @(posedge system_clk); #1; end
        rx_ready = 1'b1;
      end
    join
    waitDrain();

    // Async reset mid-data with a word still pending.
    rx_ready = 1'b0;
    applyStimulus(8'h5A, 0, 0, 0, 1, 1);
    parity_en = 1'b0;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b1);
    rx_in = 1'b0;
    repeat (20) @(posedge system_clk);
    #1;
    checkOutput("t6_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_valid", rx_valid, 0);
    checkOutput("t6_data", rx_data, 0);
    checkOutput("t6_perr", parity_err, 0);
    checkOutput("t6_ferr", frame_err, 0);
    checkOutput("t6_overrun", overrun, 0);
    checkOutput("t6_busy", busy, 0);
    sb.delete();
    rx_in = 1'b1;
    repeat (4) @(posedge system_clk);
    #1;
    reset_n  = 1'b1;
    rx_ready = 1'b1;
    repeat (10) @(posedge system_clk);
    #1;
    applyStimulus(8'hF0, 0, 0, 0, 1, 1);
    waitDrain();

    rand_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      bit pen, podd, pbit, stop;
      d    = 8'($urandom);
      pen  = ($urandom % 2) == 1;
      podd = ($urandom % 2) == 1;
      pbit = ($urandom % 2) == 1;
      stop = ($urandom % 4) != 0;
      applyStimulus(d, pen, podd, pbit, stop, 1);
      repeat ($urandom_range(4, 40)) @(posedge system_clk);
      #1;
    end
    waitDrain();
    rand_ready = 1'b0;
    rx_ready   = 1'b1;

    repeat (5) @(posedge system_clk);
    #1;
    checkOutput("overrun_count", overrun_cnt, exp_overruns);
    $display("Result: errors=%0d of %0d checks", error_cnt, check_cnt);
    $finish;
  end

endmodule
